pwm_ramp_ctrl: RTL and testbench

//  Upstream control stage for pwm_gen: accepts duty/period commands over a valid/ready handshake and drives period, h_time and en.

---
 rtl/pwm_ramp_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: upstream control stage for pwm_gen.
//
// Accepts duty/period commands over a valid/ready handshake and drives pwm_gen's period, h_time
// and en. h_time is slewed toward a target by a programmable step once per PWM period (soft start
// and soft stop). An internal period counter mirrors pwm_gen's CNT, so every update lands on the
// pwm_gen wrap cycle. rst must be the inverse of pwm_gen's rst_n to keep the counters aligned.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   cmd_valid    command present
//   cmd_ready    command can be accepted this cycle
//   cmd_period   requested PWM period in clk cycles (clamped to MIN_PERIOD)
//   cmd_h_target requested final high time in clk cycles (clamped to the period)
//   cmd_step     h_time change per period (0 is treated as 1)
//   cmd_stop     pulse: ramp h_time to 0, then disable
//   period       to pwm_gen.period
//   h_time       to pwm_gen.h_time
//   en           to pwm_gen.en
//   busy         high while ramping or stopping
//   done         one-cycle pulse when a ramp reaches its target or a stop completes
module pwm_ramp_ctrl #(
    parameter int unsigned W          = 16,
    parameter int unsigned DEF_PERIOD = 1000,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_period,
    input  logic [W-1:0] cmd_h_target,
    input  logic [W-1:0] cmd_step,
    input  logic         cmd_stop,
    output logic [W-1:0] period,
    output logic [W-1:0] h_time,
    output logic         en,
    output logic         busy,
    output logic         done
);

    localparam logic [W-1:0] DefPeriod = W'(DEF_PERIOD);
    localparam logic [W-1:0] MinPeriod = W'(MIN_PERIOD);
    localparam logic [W-1:0] One       = W'(1);

    typedef enum logic [1:0] {StIdle, StRamp, StHold, StStop} state_e;

    state_e       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] h_time_q, h_time_d;
    logic         en_q, en_d;
    logic         done_q, done_d;
    // Shadow copy of the last accepted command (clamped).
    logic [W-1:0] sp_q, sp_d;
    logic [W-1:0] st_q, st_d;
    logic [W-1:0] ss_q, ss_d;

    logic [W-1:0] sp_in, st_in, ss_in;
    logic         accept;
    logic         boundary;
    logic [W:0]   cnt_inc;
    logic         up;
    logic [W-1:0] diff;
    logic [W:0]   h_up;
    logic [W-1:0] h_dn_sat;

    // Clamp incoming command fields.
    always_comb begin
        sp_in = (cmd_period < MinPeriod) ? MinPeriod : cmd_period;
        st_in = (cmd_h_target > sp_in) ? sp_in : cmd_h_target;
        ss_in = (cmd_step == '0) ? One : cmd_step;
    end

    // A stop in HOLD takes priority over a simultaneous command, so ready drops with it.
    assign cmd_ready = (state_q == StIdle) || ((state_q == StHold) && !cmd_stop);
    assign accept    = cmd_valid && cmd_ready;

    // Wrap detection matches pwm_gen: last count of the period, never while idle.
    assign cnt_inc  = {1'b0, cnt_q} + {1'b0, One};
    assign boundary = (cnt_inc >= {1'b0, period_q}) && (state_q != StIdle);

    // Ramp arithmetic: subtraction is ordered so it never wraps; the rise saturates.
    always_comb begin
        up       = st_q > h_time_q;
        diff     = up ? (st_q - h_time_q) : (h_time_q - st_q);
        h_up     = {1'b0, h_time_q} + {1'b0, ss_q};
        h_dn_sat = (h_time_q > ss_q) ? (h_time_q - ss_q) : '0;
    end

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        h_time_d = h_time_q;
        en_d     = en_q;
        done_d   = 1'b0;
        sp_d     = sp_q;
        st_d     = st_q;
        ss_d     = ss_q;

        if (state_q == StIdle || boundary) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + One;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sp_d     = sp_in;
                    st_d     = st_in;
                    ss_d     = ss_in;
                    period_d = sp_in;
                    en_d     = 1'b1;
                    cnt_d    = '0;
                    state_d  = StRamp;
                end
            end
            StRamp: begin
                if (cmd_stop) begin
                    st_d    = '0;
                    state_d = StStop;
                end else if (boundary) begin
                    // A period retargeted from HOLD takes effect here, with the first step.
                    period_d = sp_q;
                    if (diff <= ss_q) begin
                        h_time_d = st_q;
                        done_d   = 1'b1;
                        state_d  = StHold;
                    end else if (up) begin
                        h_time_d = h_up[W] ? '1 : h_up[W-1:0];
                    end else begin
                        h_time_d = h_time_q - ss_q;
                    end
                end
            end
            StHold: begin
                if (cmd_stop) begin
                    st_d    = '0;
                    state_d = StStop;
                end else if (accept) begin
                    sp_d    = sp_in;
                    st_d    = st_in;
                    ss_d    = ss_in;
                    state_d = StRamp;
                end
            end
            StStop: begin
                if (boundary) begin
                    if (h_time_q == '0) begin
                        en_d    = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        h_time_d = h_dn_sat;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            period_q <= DefPeriod;
            h_time_q <= '0;
            en_q     <= 1'b0;
            done_q   <= 1'b0;
            sp_q     <= DefPeriod;
            st_q     <= '0;
            ss_q     <= One;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            h_time_q <= h_time_d;
            en_q     <= en_d;
            done_q   <= done_d;
            sp_q     <= sp_d;
            st_q     <= st_d;
            ss_q     <= ss_d;
        end
    end

    assign period = period_q;
    assign h_time = h_time_q;
    assign en     = en_q;
    assign done   = done_q;
    assign busy   = (state_q == StRamp) || (state_q == StStop);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl: a cycle-counted vector table plus hand-written corner cases.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_period;
    logic [15:0] cmd_h_target;
    logic [15:0] cmd_step;
    logic        cmd_stop;
    logic [15:0] period;
    logic [15:0] h_time;
    logic        en;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pwm_ramp_ctrl #(
        .W         (16),
        .DEF_PERIOD(1000),
        .MIN_PERIOD(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_period  (cmd_period),
        .cmd_h_target(cmd_h_target),
        .cmd_step    (cmd_step),
        .cmd_stop    (cmd_stop),
        .period      (period),
        .h_time      (h_time),
        .en          (en),
        .busy        (busy),
        .done        (done)
    );

    // Inputs are held for n clock edges, then outputs are compared.
    typedef struct {
        int rst;
        int vld;
        int per;
        int tgt;
        int stp;
        int stop;
        int n;
        int e_per;
        int e_h;
        int e_en;
        int e_rdy;
        int e_busy;
        int e_done;
    } vec_t;

    vec_t vecs[28];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input int e_per, input int e_h, input int e_en,
                             input int e_rdy, input int e_busy, input int e_done);
        chk({tag, ".period"}, int'(period), e_per);
        chk({tag, ".h_time"}, int'(h_time), e_h);
        chk({tag, ".en"}, int'(en), e_en);
        chk({tag, ".cmd_ready"}, int'(cmd_ready), e_rdy);
        chk({tag, ".busy"}, int'(busy), e_busy);
        chk({tag, ".done"}, int'(done), e_done);
    endtask

    task automatic drive(input int r, input int v, input int p, input int t, input int s,
                         input int st);
        rst          = 1'(r);
        cmd_valid    = 1'(v);
        cmd_period   = 16'(p);
        cmd_h_target = 16'(t);
        cmd_step     = 16'(s);
        cmd_stop     = 1'(st);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance n edges with the current inputs, then go idle and settle before checking.
    task automatic tick_idle(input int n);
        tick(n);
        drive(0, 0, 0, 0, 0, 0);
        #1;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        //            rst vld per tgt stp stop n   per   h  en rdy busy done
        // Reset, then soft start 10/6/2.
        vecs[0]  = '{1, 0, 0,  0,  0, 0, 3,  1000, 0, 0, 1, 0, 0};
        vecs[1]  = '{0, 1, 10, 6,  2, 0, 1,  10,   0, 1, 0, 1, 0};
        vecs[2]  = '{0, 0, 0,  0,  0, 0, 9,  10,   0, 1, 0, 1, 0};
        vecs[3]  = '{0, 0, 0,  0,  0, 0, 1,  10,   2, 1, 0, 1, 0};
        vecs[4]  = '{0, 0, 0,  0,  0, 0, 10, 10,   4, 1, 0, 1, 0};
        vecs[5]  = '{0, 0, 0,  0,  0, 0, 10, 10,   6, 1, 1, 0, 1};
        vecs[6]  = '{0, 0, 0,  0,  0, 0, 1,  10,   6, 1, 1, 0, 0};
        // Retarget from HOLD: period waits for the boundary.
        vecs[7]  = '{0, 1, 20, 1,  3, 0, 1,  10,   6, 1, 0, 1, 0};
        vecs[8]  = '{0, 0, 0,  0,  0, 0, 7,  10,   6, 1, 0, 1, 0};
        vecs[9]  = '{0, 0, 0,  0,  0, 0, 1,  20,   3, 1, 0, 1, 0};
        vecs[10] = '{0, 0, 0,  0,  0, 0, 19, 20,   3, 1, 0, 1, 0};
        vecs[11] = '{0, 0, 0,  0,  0, 0, 1,  20,   1, 1, 1, 0, 1};
        vecs[12] = '{0, 0, 0,  0,  0, 0, 1,  20,   1, 1, 1, 0, 0};
        // Reset from HOLD, then clamps: period 1->2, target 50->2, step 0->1.
        vecs[13] = '{1, 0, 0,  0,  0, 0, 1,  1000, 0, 0, 1, 0, 0};
        vecs[14] = '{0, 1, 1,  50, 0, 0, 1,  2,    0, 1, 0, 1, 0};
        vecs[15] = '{0, 0, 0,  0,  0, 0, 1,  2,    0, 1, 0, 1, 0};
        vecs[16] = '{0, 0, 0,  0,  0, 0, 1,  2,    1, 1, 0, 1, 0};
        vecs[17] = '{0, 0, 0,  0,  0, 0, 1,  2,    1, 1, 0, 1, 0};
        vecs[18] = '{0, 0, 0,  0,  0, 0, 1,  2,    2, 1, 1, 0, 1};
        vecs[19] = '{0, 0, 0,  0,  0, 0, 1,  2,    2, 1, 1, 0, 0};
        // Ramp to 4, then stop with a competing command.
        vecs[20] = '{0, 1, 10, 8,  2, 0, 1,  2,    2, 1, 0, 1, 0};
        vecs[21] = '{0, 0, 0,  0,  0, 0, 2,  10,   4, 1, 0, 1, 0};
        vecs[22] = '{0, 1, 30, 5,  1, 1, 1,  10,   4, 1, 0, 1, 0};
        vecs[23] = '{0, 0, 0,  0,  0, 0, 8,  10,   4, 1, 0, 1, 0};
        vecs[24] = '{0, 0, 0,  0,  0, 0, 1,  10,   2, 1, 0, 1, 0};
        vecs[25] = '{0, 0, 0,  0,  0, 0, 10, 10,   0, 1, 0, 1, 0};
        vecs[26] = '{0, 0, 0,  0,  0, 0, 10, 10,   0, 0, 1, 0, 1};
        vecs[27] = '{0, 0, 0,  0,  0, 0, 1,  10,   0, 0, 1, 0, 0};

        #2;
        for (int i = 0; i < 28; i++) begin
            drive(vecs[i].rst, vecs[i].vld, vecs[i].per, vecs[i].tgt, vecs[i].stp,
                  vecs[i].stop);
            tick_idle(vecs[i].n);
            check_all($sformatf("v%0d", i), vecs[i].e_per, vecs[i].e_h, vecs[i].e_en,
                      vecs[i].e_rdy, vecs[i].e_busy, vecs[i].e_done);
        end

        // Reset in the middle of a ramp.
        drive(0, 1, 10, 6, 2, 0);
        tick_idle(1);
        check_all("rr.start", 10, 0, 1, 0, 1, 0);
        tick_idle(10);
        check_all("rr.step", 10, 2, 1, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick_idle(1);
        check_all("rr.reset", 1000, 0, 0, 1, 0, 0);

        // Target equal to current h_time completes at the first boundary.
        drive(0, 1, 5, 0, 3, 0);
        tick_idle(1);
        check_all("eq.start", 5, 0, 1, 0, 1, 0);
        tick_idle(4);
        check_all("eq.before", 5, 0, 1, 0, 1, 0);
        tick_idle(1);
        check_all("eq.done", 5, 0, 1, 1, 0, 1);

        // Stop from HOLD beats a simultaneous command; h_time already 0 so next boundary ends it.
        drive(0, 1, 50, 40, 1, 1);
        #1;
        chk("hs.ready_with_stop", int'(cmd_ready), 0);
        tick_idle(1);
        check_all("hs.stop", 5, 0, 1, 0, 1, 0);
        tick_idle(3);
        check_all("hs.before", 5, 0, 1, 0, 1, 0);
        tick_idle(1);
        check_all("hs.end", 5, 0, 0, 1, 0, 1);
        tick_idle(1);
        check_all("hs.after", 5, 0, 0, 1, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
